// File: rtl/board_io_ctrl.sv
// Board I/O front end: synchronises and debounces raw buttons/switches into levels plus
// edge pulses, and drives LEDs with per-channel PWM brightness and enable.
module board_io_ctrl #(
  parameter int unsigned N_IN      = 8,
  parameter int unsigned N_LED     = 4,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned PWM_W     = 8
) (
  input  logic                   CLK,
  input  logic                   CK_RST,
  input  logic [N_IN-1:0]        IN_RAW,
  output logic [N_IN-1:0]        IN_LEVEL,
  output logic [N_IN-1:0]        IN_RISE,
  output logic [N_IN-1:0]        IN_FALL,
  input  logic [N_LED*PWM_W-1:0] LED_DUTY,
  input  logic [N_LED-1:0]       LED_EN,
  output logic [N_LED-1:0]       LED_OUT,
  output logic                   PWM_SYNC
);

  localparam int unsigned CntW = $clog2(DB_CYCLES);
  localparam logic [CntW-1:0] DbMax = CntW'(DB_CYCLES - 1);
  // Period is 2^PWM_W-1 so that an all-ones duty keeps the LED permanently on.
  localparam logic [PWM_W-1:0] PcntMax = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [N_IN-1:0]             sync1_q, sync1_d;
  logic [N_IN-1:0]             sync2_q, sync2_d;
  logic [N_IN-1:0][CntW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]             level_q, level_d;
  logic [N_IN-1:0]             rise_q, rise_d;
  logic [N_IN-1:0]             fall_q, fall_d;
  logic [PWM_W-1:0]            pcnt_q, pcnt_d;
  logic [N_LED-1:0][PWM_W-1:0] shadow_q, shadow_d;
  logic [N_LED-1:0]            led_q, led_d;
  logic                        psync_q, psync_d;

  always_comb begin
    sync1_d = IN_RAW;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DbMax) begin
        level_d[i] = sync2_q[i];
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    pcnt_d   = (pcnt_q == PcntMax) ? '0 : pcnt_q + 1'b1;
    shadow_d = shadow_q;
    // Duty is only sampled at the wrap so a period never mixes two duty values.
    if (pcnt_q == PcntMax) begin
      shadow_d = LED_DUTY;
    end
    for (int i = 0; i < int'(N_LED); i++) begin
      led_d[i] = LED_EN[i] & (pcnt_q < shadow_q[i]);
    end
    psync_d = (pcnt_q == '0);
  end

  always_ff @(posedge CLK or negedge CK_RST) begin
    if (!CK_RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pcnt_q   <= '0;
      shadow_q <= '0;
      led_q    <= '0;
      psync_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pcnt_q   <= pcnt_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
      psync_q  <= psync_d;
    end
  end

  assign IN_LEVEL = level_q;
  assign IN_RISE  = rise_q;
  assign IN_FALL  = fall_q;
  assign LED_OUT  = led_q;
  assign PWM_SYNC = psync_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl: edge-pulse scoreboard checked every cycle, plus
// per-period LED high-count scoreboard for the PWM path.
module tb_board_io_ctrl;

  localparam int unsigned NIn  = 8;
  localparam int unsigned NLed = 4;
  localparam int unsigned Db   = 4;
  localparam int unsigned PwmW = 4;

  logic              CLK;
  logic              CK_RST;
  logic [NIn-1:0]    IN_RAW;
  logic [NIn-1:0]    IN_LEVEL;
  logic [NIn-1:0]    IN_RISE;
  logic [NIn-1:0]    IN_FALL;
  logic [15:0]       LED_DUTY;
  logic [NLed-1:0]   LED_EN;
  logic [NLed-1:0]   LED_OUT;
  logic              PWM_SYNC;

  board_io_ctrl #(
    .N_IN      (NIn),
    .N_LED     (NLed),
    .DB_CYCLES (Db),
    .PWM_W     (PwmW)
  ) dut (
    .CLK      (CLK),
    .CK_RST   (CK_RST),
    .IN_RAW   (IN_RAW),
    .IN_LEVEL (IN_LEVEL),
    .IN_RISE  (IN_RISE),
    .IN_FALL  (IN_FALL),
    .LED_DUTY (LED_DUTY),
    .LED_EN   (LED_EN),
    .LED_OUT  (LED_OUT),
    .PWM_SYNC (PWM_SYNC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int             cyc;
    logic [NIn-1:0] rise;
    logic [NIn-1:0] fall;
  } ev_t;

  ev_t exp_q[$];
  int  exp_led_q[$];
  int  cyc;
  int  checks;
  int  errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge pulses become visible DB+2 sample points after the raw input is driven.
  task automatic expect_edge(input logic [NIn-1:0] rise, input logic [NIn-1:0] fall);
    ev_t e;
    e.cyc  = cyc + int'(Db) + 2;
    e.rise = rise;
    e.fall = fall;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    ev_t e;
    @(negedge CLK);
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("missed_edge", 32'(e.cyc), 32'(cyc));
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("rise", 32'(IN_RISE), 32'(e.rise));
      check("fall", 32'(IN_FALL), 32'(e.fall));
    end else begin
      check("no_pulse", 32'({IN_RISE, IN_FALL}), 32'(0));
    end
  endtask

  task automatic wait_sync();
    int n;
    n = 0;
    while (!PWM_SYNC && n < 20) begin
      tick();
      n++;
    end
    check("sync_found", 32'(PWM_SYNC), 32'(1));
  endtask

  // Starts on a PWM_SYNC cycle and counts LED high cycles over one full period.
  task automatic measure(input int mid_at, input logic [15:0] mid_duty);
    int cnt [4];
    int syncs;
    int e;
    cnt   = '{0, 0, 0, 0};
    syncs = 0;
    for (int j = 0; j < 15; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (LED_OUT[i]) cnt[i]++;
      end
      if (j > 0 && PWM_SYNC) syncs++;
      if (j == mid_at) LED_DUTY = mid_duty;
      tick();
    end
    check("sync_gap", 32'(PWM_SYNC), 32'(1));
    check("sync_extra", 32'(syncs), 32'(0));
    for (int i = 0; i < 4; i++) begin
      e = (exp_led_q.size() > 0) ? exp_led_q.pop_front() : -1;
      check($sformatf("led_cnt%0d", i), 32'(cnt[i]), 32'(e));
    end
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    CK_RST   = 1'b1;
    IN_RAW   = '0;
    LED_DUTY = '0;
    LED_EN   = '0;
    #1 CK_RST = 1'b0;
    #1;
    check("rst_level", 32'(IN_LEVEL), 32'(0));
    check("rst_pulses", 32'({IN_RISE, IN_FALL}), 32'(0));
    check("rst_led", 32'({LED_OUT, PWM_SYNC}), 32'(0));
    repeat (2) tick();
    CK_RST = 1'b1;

    // Accept ch5 and light all LEDs, then reset in the middle of a ch5 fall debounce.
    IN_RAW[5] = 1'b1;
    expect_edge(8'h20, 8'h00);
    LED_DUTY = 16'hFFFF;
    LED_EN   = 4'hF;
    repeat (32) tick();
    check("pre_level", 32'(IN_LEVEL), 32'(8'h20));
    check("pre_led", 32'(LED_OUT), 32'(4'hF));
    IN_RAW[5] = 1'b0;
    repeat (3) tick();
    @(posedge CLK);
    #2 CK_RST = 1'b0;
    #1;
    check("async_level", 32'(IN_LEVEL), 32'(0));
    check("async_pulses", 32'({IN_RISE, IN_FALL}), 32'(0));
    check("async_led", 32'({LED_OUT, PWM_SYNC}), 32'(0));
    repeat (2) tick();
    CK_RST = 1'b1;
    tick();
    check("post_rst_led", 32'(LED_OUT), 32'(0));
    check("post_rst_sync", 32'(PWM_SYNC), 32'(1));
    repeat (12) tick();
    check("shadow_zero", 32'(LED_OUT), 32'(0));
    repeat (5) tick();
    check("led_after_wrap", 32'(LED_OUT), 32'(4'hF));

    // Clean step on ch0.
    IN_RAW[0] = 1'b1;
    expect_edge(8'h01, 8'h00);
    repeat (5) tick();
    check("step_before", 32'(IN_LEVEL[0]), 32'(0));
    tick();
    check("step_after", 32'(IN_LEVEL[0]), 32'(1));
    tick();

    // Bounce rejection on ch1.
    for (int t = 0; t < 15; t++) begin
      IN_RAW[1] = ~IN_RAW[1];
      repeat (2) tick();
    end
    IN_RAW[1] = 1'b0;
    repeat (8) tick();
    check("bounce_level", 32'(IN_LEVEL[1]), 32'(0));

    // Simultaneous rise on ch2 and fall on ch3.
    IN_RAW[3] = 1'b1;
    expect_edge(8'h08, 8'h00);
    repeat (8) tick();
    IN_RAW[2] = 1'b1;
    IN_RAW[3] = 1'b0;
    expect_edge(8'h04, 8'h08);
    repeat (8) tick();
    check("simul_level", 32'(IN_LEVEL), 32'(8'h05));

    // PWM duty 5, 0, 15, 8.
    LED_DUTY = {4'd8, 4'd15, 4'd0, 4'd5};
    exp_led_q.push_back(5);
    exp_led_q.push_back(0);
    exp_led_q.push_back(15);
    exp_led_q.push_back(8);
    tick();
    wait_sync();
    tick();
    wait_sync();
    measure(-1, 16'h0);

    // Mid-period duty change on ch0 only takes effect next period.
    exp_led_q.push_back(5);
    exp_led_q.push_back(0);
    exp_led_q.push_back(15);
    exp_led_q.push_back(8);
    exp_led_q.push_back(10);
    exp_led_q.push_back(0);
    exp_led_q.push_back(15);
    exp_led_q.push_back(8);
    measure(5, {4'd8, 4'd15, 4'd0, 4'd10});
    measure(-1, 16'h0);

    // Enable is not shadowed.
    check("en_before", 32'(LED_OUT[3]), 32'(1));
    LED_EN = 4'h7;
    tick();
    check("en_cleared", 32'(LED_OUT[3]), 32'(0));
    check("en_other", 32'(LED_OUT[2]), 32'(1));

    // Input held high through reset produces one rise after release.
    IN_RAW = 8'h40;
    CK_RST = 1'b0;
    repeat (3) tick();
    check("rst2_level", 32'(IN_LEVEL), 32'(0));
    CK_RST = 1'b1;
    expect_edge(8'h40, 8'h00);
    repeat (10) tick();
    check("held_level", 32'(IN_LEVEL), 32'(8'h40));
    check("edge_q_empty", 32'(exp_q.size()), 32'(0));
    check("led_q_empty", 32'(exp_led_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
